ecc_enc_arbiter: RTL and testbench

ECC_ENC_ARBITER -- requirements
Module: ecc_enc_arbiter

---
 rtl/ecc_enc_arbiter_pkg.sv | 12 +
 rtl/hamming_encoder26.sv | 27 ++
 rtl/ecc_enc_arbiter.sv | 90 +++++++++
 tb/tb_ecc_enc_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_enc_arbiter_pkg.sv
// rtl/ecc_enc_arbiter_pkg.sv - shared widths and index-width helper for the ECC encoder arbiter
package ecc_enc_arbiter_pkg;

    localparam int DW_DEF = 26;
    localparam int CW_DEF = 5;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hamming_encoder26.sv
// rtl/hamming_encoder26.sv - Hamming(31,26) check-code generator
//   data : 26-bit payload
//   code : 5-bit check code, bit k = parity over codeword positions with bit k set
module hamming_encoder26
    import ecc_enc_arbiter_pkg::*;
(
    input  logic [DW_DEF-1:0] data,
    output logic [CW_DEF-1:0] code
);

    // Data bits occupy the non-power-of-two codeword positions 3,5,6,7,9,...
    // XOR-ing the position numbers of all set data bits yields every parity
    // bit at once.
    always_comb begin
        logic [4:0] pos;
        code = '0;
        pos  = 5'd3;
        for (int j = 0; j < DW_DEF; j++) begin
            code = code ^ ({5{data[j]}} & pos);
            pos  = pos + 5'd1;
            if ((pos & (pos - 5'd1)) == 5'd0) begin
                pos = pos + 5'd1;
            end
        end
    end

endmodule

// File: rtl/ecc_enc_arbiter.sv
// rtl/ecc_enc_arbiter.sv - round-robin arbiter sharing one Hamming encoder, single-entry output register
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : when low, no new grants are issued
//   req_valid/req_data  : per-requester valid and data (requester i at [i*DW +: DW])
//   req_ready           : one-hot accept for the granted requester
//   out_valid/out_ready : output register handshake
//   out_data/out_code   : held word and its check code
//   out_src             : index of the requester that supplied the held word
//   busy                : out_valid or any request pending
module ecc_enc_arbiter
    import ecc_enc_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    localparam int IW  = idx_w(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_code,
    output logic [IW-1:0]      out_src,
    output logic               busy
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic          gnt_found;
    logic          can_load;
    logic          xfer;
    logic [DW-1:0] sel_data;
    logic [CW-1:0] sel_code;

    // First valid requester at or after ptr, wrapping past NREQ-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int p;
            p = int'(ptr) + k;
            if (p >= NREQ) begin
                p = p - NREQ;
            end
            if (!gnt_found && req_valid[p]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(p);
            end
        end
    end

    assign can_load  = en && (!out_valid || out_ready);
    // rst_n gates the accept so nothing is handshaken while reset is held.
    assign xfer      = rst_n && can_load && gnt_found;
    assign req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;
    assign busy      = out_valid || (|req_valid);

    assign sel_data = req_data[int'(gnt_idx)*DW +: DW];

    // Encoding happens on the mux output so the registered code always
    // matches the registered data.
    hamming_encoder26 u_enc (
        .data (sel_data),
        .code (sel_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_code  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_code  <= sel_code;
            out_src   <= gnt_idx;
            ptr       <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ecc_enc_arbiter.sv
// tb/tb_ecc_enc_arbiter.sv - self-checking bench for ecc_enc_arbiter against a behavioural model
module tb_ecc_enc_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 26;
    localparam int CW   = 5;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_code;
    logic [1:0]        out_src;
    logic              busy;

    logic [DW-1:0] wd [NREQ];

    assign req_data = {wd[3], wd[2], wd[1], wd[0]};

    ecc_enc_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_code  (out_code),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // model state
    int          m_ptr;
    bit          m_valid;
    logic [25:0] m_data;
    int          m_src;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_pow2(input int v);
        return (v & (v - 1)) == 0;
    endfunction

    // Build the 31-bit codeword, then each parity bit is the XOR of the
    // data positions whose binary index has that bit set.
    function automatic logic [4:0] ref_code(input logic [25:0] d);
        bit cw [32];
        int j;
        logic [4:0] c;
        j = 0;
        for (int p = 0; p < 32; p++) cw[p] = 1'b0;
        for (int p = 1; p < 32; p++) begin
            if (!is_pow2(p)) begin
                cw[p] = d[j];
                j++;
            end
        end
        c = '0;
        for (int k = 0; k < 5; k++) begin
            bit par;
            par = 1'b0;
            for (int p = 1; p < 32; p++) begin
                if (!is_pow2(p) && ((p >> k) & 1) == 1) par = par ^ cw[p];
            end
            c[k] = par;
        end
        return c;
    endfunction

    function automatic int ref_grant();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
    endtask

    // One clock: check combinational accept, clock it, check registered outputs.
    task automatic step();
        bit cl;
        int g;
        logic [NREQ-1:0] exp_rdy;
        #2;
        cl = en && (!m_valid || out_ready);
        g  = cl ? ref_grant() : -1;
        exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("busy", 32'(busy), 32'(m_valid || (|req_valid)));
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = wd[g];
            m_src   = g;
            m_ptr   = (g + 1) % NREQ;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data", 32'(out_data), 32'(m_data));
        check_eq("out_code", 32'(out_code), 32'(ref_code(m_data)));
        check_eq("out_src", 32'(out_src), 32'(m_src));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_code", 32'(out_code), 32'd0);
        check_eq("rst_src", 32'(out_src), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = 4'hf;
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) wd[i] = 26'h1555555 + 26'(i);
        #3;
        do_reset();

        // single request, data 1
        req_valid = 4'b0001;
        wd[0] = 26'h0000001;
        step();
        check_eq("d036_code", 32'(out_code), 32'h03);
        check_eq("d036_src", 32'(out_src), 32'd0);
        check_eq("d036_valid", 32'(out_valid), 32'd1);
        req_valid = '0;
        step();

        // all-ones then zero data from requester 2
        req_valid = 4'b0100;
        wd[2] = 26'h3FFFFFF;
        step();
        check_eq("d037_code1", 32'(out_code), 32'h1f);
        check_eq("d037_src", 32'(out_src), 32'd2);
        wd[2] = 26'h0;
        step();
        check_eq("d037_code0", 32'(out_code), 32'h00);
        req_valid = '0;
        step();

        // round robin with all requesters valid
        do_reset();
        req_valid = 4'hf;
        for (int i = 0; i < NREQ; i++) wd[i] = 26'($urandom);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("d038_src", 32'(out_src), 32'(i % NREQ));
            check_eq("d038_valid", 32'(out_valid), 32'd1);
        end

        // backpressure holding a word from requester 1
        do_reset();
        req_valid = 4'b0010;
        step();
        req_valid = 4'hf;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("d039_hold_src", 32'(out_src), 32'd1);
        end
        out_ready = 1'b1;
        step();
        check_eq("d039_next_src", 32'(out_src), 32'd2);

        // en low: drain, no grants, ptr holds
        step();
        en = 1'b0;
        step();
        check_eq("d040_drained", 32'(out_valid), 32'd0);
        step();
        en = 1'b1;
        step();
        check_eq("d040_src", 32'(out_src), 32'd0);

        // asynchronous reset mid-stream
        step();
        #2;
        do_reset();
        req_valid = 4'b0110;
        step();
        check_eq("d041_src", 32'(out_src), 32'd1);

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            if (($urandom % 80) == 0) begin
                do_reset();
            end
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) wd[i] = 26'($urandom);
            en        = ($urandom % 8) != 0;
            out_ready = ($urandom % 4) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
